// File: rtl/tetris_pkg.sv
// Shared playfield constants: requester indices, board RAM geometry and the
// arbiter state type used by the board memory arbiter.
package tetris_pkg;

  localparam int REQ_PLACER   = 0;
  localparam int REQ_CLEAR    = 1;
  localparam int REQ_RENDER   = 2;
  localparam int NUM_REQ      = 3;

  localparam int BOARD_ADDR_W = 8;
  localparam int BOARD_DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/board_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: scans (last+1), (last+2), last and
// returns the first unmasked requester as a one-hot winner.
module rr_pick
  import tetris_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         idx;
  logic               found;

  assign cand = req & ~mask;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(last) + k) % NUM_REQ);
      if (!found && cand[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Round-robin, burst-locking arbiter that owns the single-port board RAM and
// shares it between the piece placer, line clearer and display renderer.
module board_mem_arbiter
  import tetris_pkg::*;
#(
  parameter int ADDR_W    = BOARD_ADDR_W,
  parameter int DATA_W    = BOARD_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output arb_state_e                dbg_state
);

  localparam int               CNT_W   = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [1:0]         last_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               owner_req;
  logic               others_req;
  logic               capped;
  logic               rearb;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] pick;

  // Handshake: a requester raises req and holds req/we/addr/wdata stable until
  // gnt is seen; every cycle with gnt[i] & req[i] is one RAM access, and the
  // owner ends its burst by dropping req (gnt falls on the following edge).
  assign owner_req  = |(gnt_q & req);
  assign others_req = |(req & ~gnt_q);
  assign capped     = (cnt_q == CNT_MAX) && others_req;
  assign rearb      = !owner_req || capped;
  assign mask       = (owner_req && capped) ? gnt_q : '0;

  rr_pick u_rr_pick (
    .req    (req),
    .last   (last_q),
    .mask   (mask),
    .winner (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      last_q   <= 2'd2;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= gnt_q & req & ~req_we;
      case (state_q)
        ST_IDLE: begin
          if (|pick) begin
            state_q <= ST_OWN;
            gnt_q   <= pick;
            last_q  <= onehot_to_idx(pick);
            cnt_q   <= '0;
          end
        end
        ST_OWN: begin
          // Release and re-grant share one edge so the RAM never idles.
          if (rearb) begin
            if (|pick) begin
              gnt_q  <= pick;
              last_q <= onehot_to_idx(pick);
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
            cnt_q <= '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_we    = |(gnt_q & req & req_we);
  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign busy      = |gnt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Shares the single-port board RAM (playfield cells) between three requesters: the piece placer (index 0), the line clearer (index 1) and the display renderer (index 2). Grants are round-robin with burst locking, so a whole piece placement of about 14 cycles completes without interleaving. A burst-length cap keeps the renderer from starving. The block sits between the game datapath blocks and the board RAM, and owns the RAM's `we`/`addr`/`data` pins.

## Interface
- `ADDR_W`, 8: board RAM address width.
- `DATA_W`, 8: board RAM data width.
- `MAX_BURST`, 16: maximum granted cycles before a forced release when others are waiting; must be ≥ 2.
- `clk`  in  1: system clock (50 MHz).
- `rst`  in  1: asynchronous reset, active-low.
- `req`  in  3: per-requester access request; held high for the whole burst.
- `req_we`  in  3: per-requester write enable; 0 means read.
- `req_addr`  in  3*ADDR_W: per-requester address; slice i belongs to requester i.
- `req_wdata`  in  3*DATA_W: per-requester write data.
- `gnt`  out  3: one-hot grant, registered.
- `rdata`  out  DATA_W: RAM read data, broadcast to all requesters.
- `rvalid`  out  3: one-hot; `rdata` is valid for requester i.
- `mem_we`  out  1: RAM write enable.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  DATA_W: RAM write data.
- `mem_rdata`  in  DATA_W: RAM read data, one-cycle synchronous read.
- `busy`  out  1: high when any `gnt` bit is set.

## Operation
- States:
  - IDLE: no owner.
  - OWN: exactly one `gnt` bit set.
- Arbitration (IDLE, or release from OWN): search order is `(last+1)%3`, `(last+2)%3`, `last`. The first requester with `req` high wins. `last` then becomes the winner.
- In OWN, the burst counter increments each cycle.
- Release from OWN happens when either:
  - the owner's `req` is low, or
  - the counter equals `MAX_BURST-1` and another `req` is high.
- On release, re-arbitration happens on the same edge, so there is no bubble. A capped owner that still holds `req` is excluded from that one arbitration.
- Counter clears on every new grant.
- Mux: `mem_addr`/`mem_wdata` come from the owner's slice; in IDLE they are 0.
  - `mem_we = |(gnt & req & req_we)`.
  - A non-granted requester's `req_we` never reaches the RAM.
- Read return: a granted cycle with `req_we[i]=0` sets `rvalid[i]` high in the next cycle. `rdata` is `mem_rdata` passed through.
- A requester keeps its signals stable while `req` is high and `gnt` is low.

## Timing
- Reset (`rst`=0, asynchronous):
  - `gnt`=0, `rvalid`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Counter = 0; `last`=2, so requester 0 wins first after reset.
  - State = IDLE.
- Reset mid-burst aborts the burst immediately. An in-flight `rvalid` is dropped.
- Grant latency: `req` high at edge k (IDLE) gives `gnt` high after edge k. The first access is performed at edge k+1.
- Owner drops `req` before edge k: `gnt` is low after edge k, and any other pending requester is granted at that same edge.
- Cap case: a burst can last at most `MAX_BURST` granted cycles while others wait. With no contention the owner keeps the grant indefinitely and the counter saturates.
- Simultaneous requests from IDLE resolve purely by the round-robin order from `last`.
- `rvalid` is exactly 1 cycle after the read cycle, even if the grant moved on that same edge.
- Counter width is `$clog2(MAX_BURST)`, unsigned, saturating at `MAX_BURST-1`.

## Structure
- Shared package `tetris_pkg`:
  - `REQ_PLACER=0`, `REQ_CLEAR=1`, `REQ_RENDER=2`, `NUM_REQ=3`.
  - Board address/data width constants.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `req`, `last`, `mask` and output one-hot `winner`. The parent holds the FSM, counter, mux and `rvalid` pipeline.

## Test plan
- Reset: hold `rst`=0 with `req`=3'b111 → all outputs 0. Release reset → `gnt`=3'b001 after the first edge.
- Single placer burst: `req[0]` high for 14 cycles, writing addr 0x21..0x24 with data 0x05 → each write appears on `mem_*` exactly in its granted cycle. `gnt` falls on the edge after `req[0]` drops.
- Round-robin: `req`=3'b111 with `last`=0, each owner holding `req` for 3 cycles → grant sequence 010, 100, 001, 010, with no idle cycles between grants.
- Burst cap with `MAX_BURST`=16: renderer holds `req[2]`, placer raises `req[0]` during cycle 2 → `gnt[2]` lasts exactly 16 cycles, then `gnt` becomes 3'b001 on the next edge.
- Read return: renderer reads addr 0x40 while the RAM holds 0x07 → `rvalid`=3'b100 and `rdata`=0x07 one cycle later. Non-granted `req_we[1]`=1 never asserts `mem_we`.
- Async reset mid-burst: assert `rst`=0 between edges during a placer burst → `gnt`=0 and `mem_we`=0 immediately, without waiting for a clock edge.
